// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================
// keypad_pkg : shared FSM states, key codes and row helpers
// Rev 1.0
// ============================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Keymap: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return KEY_STAR;
      4'b11_01: return 4'h0;
      4'b11_10: return KEY_HASH;
      default:  return 4'hD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_row_debouncer.sv
`default_nettype none
// ============================================================
// row_debouncer : counts consecutive cycles rows == ref_rows
// Rev 1.0
// ============================================================
module row_debouncer #(
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] rows,
  input  logic [3:0] ref_rows,
  output logic       stable_done
);

  localparam int            CW   = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic [CW-1:0] cnt;
  logic          match;

  assign match       = enable && (rows == ref_rows);
  assign stable_done = match && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!match || stable_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================
// keypad_scanner : 4x4 matrix keypad scanner, debounce, key codes
// Rev 1.0
// ============================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] digit,
  output logic       key_valid,
  output logic       enter,
  output logic       key_held
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  state_t        state, state_next;
  logic [3:0]    sync_meta, rows_s;
  logic [1:0]    col;
  logic [DW-1:0] div_cnt;
  logic [3:0]    cap_rows;
  logic [1:0]    cap_row;
  logic [3:0]    digit_q;
  logic          armed;
  logic [1:0]    quiet_cnt;
  logic          slot_end;
  logic          one_low;
  logic          stable_done;
  logic          deb_en;
  logic [3:0]    deb_ref;
  logic [3:0]    code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 4'hF;
      rows_s    <= 4'hF;
    end else begin
      sync_meta <= rows_n;
      rows_s    <= sync_meta;
    end
  end

  assign slot_end = (div_cnt == DIV_LAST);
  assign one_low  = single_low(rows_s);
  assign code     = key_code(cap_row, col);
  assign cols_n   = ~(4'b0001 << col);
  assign digit    = digit_q;

  // Same counter serves press (match captured vector) and release (match all-high).
  assign deb_en  = (state == ST_DEBOUNCE) || (state == ST_RELEASE_WAIT);
  assign deb_ref = (state == ST_DEBOUNCE) ? cap_rows : ROWS_IDLE;

  row_debouncer #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_row_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (deb_en),
    .rows       (rows_s),
    .ref_rows   (deb_ref),
    .stable_done(stable_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SCAN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    key_valid  = 1'b0;
    enter      = 1'b0;
    key_held   = 1'b0;
    case (state)
      ST_SCAN: begin
        if (slot_end && armed && one_low) state_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!one_low)         state_next = ST_SCAN;
        else if (stable_done) state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        state_next = ST_RELEASE_WAIT;
        key_held   = 1'b1;
        if (code == KEY_HASH) enter = 1'b1;
        else                  key_valid = 1'b1;
      end
      ST_RELEASE_WAIT: begin
        key_held = 1'b1;
        if (stable_done) state_next = ST_SCAN;
      end
      default: state_next = ST_SCAN;
    endcase
  end

  // A key still held across reset must not fire: presses are ignored until
  // four consecutive column samples have seen every row high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= 2'd0;
      div_cnt   <= '0;
      cap_rows  <= 4'hF;
      cap_row   <= 2'd0;
      digit_q   <= 4'h0;
      armed     <= 1'b0;
      quiet_cnt <= 2'd0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (slot_end) begin
            div_cnt <= '0;
            if (!armed) begin
              if (rows_s != ROWS_IDLE)  quiet_cnt <= 2'd0;
              else if (quiet_cnt == 2'd3) armed <= 1'b1;
              else                       quiet_cnt <= quiet_cnt + 2'd1;
            end
            if (armed && one_low) begin
              cap_rows <= rows_s;
              cap_row  <= row_index(rows_s);
            end else begin
              col <= col + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!one_low) begin
            col <= col + 2'd1;
          end else if (stable_done && (code != KEY_HASH)) begin
            digit_q <= code;
          end
        end
        ST_RELEASE_WAIT: begin
          if (stable_done) col <= col + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
